pipe_stage_skid: RTL

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer and flush-to-bubble. It replaces the fixed STALL-driven inter-stage registers (IF/ID, ID/EX, ...) with one generic block. It carries a PC plus a configurable payload at full throughput and registered backpressure. Every stage boundary of the core instantiates it; the payload width is set per boundary.

---
 rtl/pipe_stage_skid.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register: valid/ready handshake, optional two-entry skid buffer, flush-to-bubble.
// Define PIPE_SKID_EN for the skid buffer with registered IN_READY; otherwise a single register stage.
module pipe_stage_skid #(
    parameter int unsigned          PC_W      = 32,
    parameter int unsigned          PAYLOAD_W = 32,
    parameter logic [PAYLOAD_W-1:0] NOP_VALUE = {PAYLOAD_W{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 FLUSH,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [PC_W-1:0]      PC_IN,
    input  logic [PAYLOAD_W-1:0] PAYLOAD_IN,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [PC_W-1:0]      PC_OUT,
    output logic [PAYLOAD_W-1:0] PAYLOAD_OUT,
    output logic [1:0]           OCC
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
`ifdef PIPE_SKID_EN
    localparam logic [1:0] ST_FULL  = 2'd2;
`endif

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 r_out_valid;
    logic [PC_W-1:0]      r_main_pc;
    logic [PC_W-1:0]      w_main_pc_nxt;
    logic [PAYLOAD_W-1:0] r_main_pl;
    logic [PAYLOAD_W-1:0] w_main_pl_nxt;
    logic                 w_in_fire;
    logic                 w_out_fire;

`ifdef PIPE_SKID_EN
    logic [PC_W-1:0]      r_skid_pc;
    logic [PC_W-1:0]      w_skid_pc_nxt;
    logic [PAYLOAD_W-1:0] r_skid_pl;
    logic [PAYLOAD_W-1:0] w_skid_pl_nxt;
    logic                 r_in_ready;

    assign IN_READY = r_in_ready;
`else
    assign IN_READY = !r_out_valid || OUT_READY;
`endif

    assign w_in_fire   = IN_VALID && IN_READY;
    assign w_out_fire  = r_out_valid && OUT_READY;
    assign OUT_VALID   = r_out_valid;
    assign PC_OUT      = r_main_pc;
    assign PAYLOAD_OUT = r_main_pl;
    assign OCC         = r_state;

    // Next-state and next-data; FLUSH overrides every handshake event.
    always_comb begin
        w_state_nxt   = r_state;
        w_main_pc_nxt = r_main_pc;
        w_main_pl_nxt = r_main_pl;
`ifdef PIPE_SKID_EN
        w_skid_pc_nxt = r_skid_pc;
        w_skid_pl_nxt = r_skid_pl;
`endif
        if (FLUSH) begin
            w_state_nxt   = ST_EMPTY;
            w_main_pc_nxt = '0;
            w_main_pl_nxt = NOP_VALUE;
`ifdef PIPE_SKID_EN
            w_skid_pc_nxt = '0;
            w_skid_pl_nxt = NOP_VALUE;
`endif
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt   = ST_BUSY;
                        w_main_pc_nxt = PC_IN;
                        w_main_pl_nxt = PAYLOAD_IN;
                    end
                end
                ST_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_pc_nxt = PC_IN;
                        w_main_pl_nxt = PAYLOAD_IN;
                    end
`ifdef PIPE_SKID_EN
                    else if (w_in_fire) begin
                        w_state_nxt   = ST_FULL;
                        w_skid_pc_nxt = PC_IN;
                        w_skid_pl_nxt = PAYLOAD_IN;
                    end
`endif
                    else if (w_out_fire) begin
                        w_state_nxt   = ST_EMPTY;
                        w_main_pc_nxt = '0;
                        w_main_pl_nxt = NOP_VALUE;
                    end
                end
`ifdef PIPE_SKID_EN
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt   = ST_BUSY;
                        w_main_pc_nxt = r_skid_pc;
                        w_main_pl_nxt = r_skid_pl;
                        w_skid_pc_nxt = '0;
                        w_skid_pl_nxt = NOP_VALUE;
                    end
                end
`endif
                default: begin
                    w_state_nxt   = ST_EMPTY;
                    w_main_pc_nxt = '0;
                    w_main_pl_nxt = NOP_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_main_pc   <= '0;
            r_main_pl   <= NOP_VALUE;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_main_pc   <= w_main_pc_nxt;
            r_main_pl   <= w_main_pl_nxt;
        end
    end

`ifdef PIPE_SKID_EN
    // Skid storage and the registered ready derived from the next occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_skid_pc  <= '0;
            r_skid_pl  <= NOP_VALUE;
            r_in_ready <= 1'b1;
        end else begin
            r_skid_pc  <= w_skid_pc_nxt;
            r_skid_pl  <= w_skid_pl_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end
`endif

endmodule
